// File: rtl/load_store_unit_if.sv
// Bundle of the core-side request/response handshake and the data-memory
// req/ack bus seen by the load/store unit. The master modport is the unit
// itself; the slave modport is the execute/writeback side plus memory.
interface load_store_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Core request
  logic              reqValid;
  logic              reqReady;
  logic              reqWrite;
  logic [2:0]        reqFunct3;
  logic [ADDR_W-1:0] reqAddr;
  logic [DATA_W-1:0] reqWdata;
  // Core response
  logic              respValid;
  logic              respReady;
  logic [DATA_W-1:0] respData;
  logic              respMisaligned;
  logic              respBusErr;
  // Memory bus
  logic              memReq;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [3:0]        memByteEn;
  logic [DATA_W-1:0] memWdata;
  logic              memAck;
  logic [DATA_W-1:0] memRdata;

  modport master (
    input  reqValid, reqWrite, reqFunct3, reqAddr, reqWdata,
    input  respReady, memAck, memRdata,
    output reqReady, respValid, respData, respMisaligned, respBusErr,
    output memReq, memWe, memAddr, memByteEn, memWdata
  );

  modport slave (
    output reqValid, reqWrite, reqFunct3, reqAddr, reqWdata,
    output respReady, memAck, memRdata,
    input  reqReady, respValid, respData, respMisaligned, respBusErr,
    input  memReq, memWe, memAddr, memByteEn, memWdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one load or store from execute, runs a single
// word-aligned req/ack bus cycle with byte enables, and returns the
// extended load data (or misaligned / bus-timeout flags) to writeback.
// All outputs come straight from registers.
module load_store_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rstn,
  load_store_unit_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Counter only has to reach TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // Access size classes; reserved funct3 codes fall back to word.
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  function automatic logic [1:0] size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: size_of = SZ_B;
      3'b001, 3'b101: size_of = SZ_H;
      default:        size_of = SZ_W;
    endcase
  endfunction

  function automatic logic is_unsigned(input logic [2:0] f3);
    is_unsigned = (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (size_of(f3))
      SZ_B:    is_misaligned = 1'b0;
      SZ_H:    is_misaligned = off[0];
      default: is_misaligned = (off != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    case (size_of(f3))
      SZ_B:    byte_en = 4'b0001 << off;
      SZ_H:    byte_en = off[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (size_of(f3))
      SZ_B:    store_data = {4{wd[7:0]}};
      SZ_H:    store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_data(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{off, 3'b000} +: 8];
    h = rd[{off[1], 4'b0000} +: 16];
    case (size_of(f3))
      SZ_B:    load_data = is_unsigned(f3) ? {24'h000000, b} : {{24{b[7]}}, b};
      SZ_H:    load_data = is_unsigned(f3) ? {16'h0000, h} : {{16{h[15]}}, h};
      default: load_data = rd;
    endcase
  endfunction

  logic [1:0]        state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              resp_mis_q, resp_mis_d;
  logic              resp_err_q, resp_err_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  // Next-state and next-output logic for the IDLE/BUS/RESP controller.
  always_comb begin
    state_d      = state_q;
    f3_d         = f3_q;
    off_d        = off_q;
    cnt_d        = cnt_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_mis_d   = resp_mis_q;
    resp_err_d   = resp_err_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        // Ready rises the cycle after reset releases, then stays up in IDLE.
        req_ready_d = 1'b1;
        if (bus.reqValid && req_ready_q) begin
          f3_d        = bus.reqFunct3;
          off_d       = bus.reqAddr[1:0];
          cnt_d       = {CNT_W{1'b0}};
          req_ready_d = 1'b0;
          if (is_misaligned(bus.reqFunct3, bus.reqAddr[1:0])) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_mis_d   = 1'b1;
            resp_data_d  = {DATA_W{1'b0}};
          end else begin
            state_d     = S_BUS;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.reqWrite;
            mem_addr_d  = {bus.reqAddr[ADDR_W-1:2], 2'b00};
            mem_be_d    = byte_en(bus.reqFunct3, bus.reqAddr[1:0]);
            mem_wdata_d = bus.reqWrite ? store_data(bus.reqFunct3, bus.reqWdata)
                                       : {DATA_W{1'b0}};
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_BUS: begin
        if (bus.memAck) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_data_d  = mem_we_q ? {DATA_W{1'b0}} : load_data(f3_q, off_q, bus.memRdata);
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          mem_addr_d   = {ADDR_W{1'b0}};
          mem_be_d     = 4'b0000;
          mem_wdata_d  = {DATA_W{1'b0}};
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_data_d  = {DATA_W{1'b0}};
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          mem_addr_d   = {ADDR_W{1'b0}};
          mem_be_d     = 4'b0000;
          mem_wdata_d  = {DATA_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RESP: begin
        if (bus.respReady) begin
          state_d      = S_IDLE;
          req_ready_d  = 1'b1;
          resp_valid_d = 1'b0;
          resp_data_d  = {DATA_W{1'b0}};
          resp_mis_d   = 1'b0;
          resp_err_d   = 1'b0;
        end else begin
          state_d = S_RESP;
        end
      end

      default: begin
        state_d      = S_IDLE;
        req_ready_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_data_d  = {DATA_W{1'b0}};
        resp_mis_d   = 1'b0;
        resp_err_d   = 1'b0;
        mem_req_d    = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = {ADDR_W{1'b0}};
        mem_be_d     = 4'b0000;
        mem_wdata_d  = {DATA_W{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      f3_q         <= 3'b000;
      off_q        <= 2'b00;
      cnt_q        <= {CNT_W{1'b0}};
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= {DATA_W{1'b0}};
      resp_mis_q   <= 1'b0;
      resp_err_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_be_q     <= 4'b0000;
      mem_wdata_q  <= {DATA_W{1'b0}};
    end else begin
      state_q      <= state_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_mis_q   <= resp_mis_d;
      resp_err_q   <= resp_err_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign bus.reqReady       = req_ready_q;
  assign bus.respValid      = resp_valid_q;
  assign bus.respData       = resp_data_q;
  assign bus.respMisaligned = resp_mis_q;
  assign bus.respBusErr     = resp_err_q;
  assign bus.memReq         = mem_req_q;
  assign bus.memWe          = mem_we_q;
  assign bus.memAddr        = mem_addr_q;
  assign bus.memByteEn      = mem_be_q;
  assign bus.memWdata       = mem_wdata_q;

endmodule
